// File: rtl/spim_xfer.sv
// spim_xfer: SPI flash frame sequencer.
// Walks one frame through instruction, address, dummy and data phases. Each
// step is handed to an external byte engine as a one-cycle boper pulse.
// Write data arrives on a ready/valid stream. Read data leaves through a
// single-entry ready/valid buffer. Every output is driven from a register.
module spim_xfer #(
    parameter int CSH_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        ins_en,
    input  logic [1:0]  ins_mode,
    input  logic [7:0]  ins,
    input  logic [2:0]  addr_len,
    input  logic [1:0]  addr_mode,
    input  logic [31:0] addr,
    input  logic [4:0]  dmy_cyc,
    input  logic        data_rd,
    input  logic [1:0]  data_mode,
    input  logic [15:0] data_len,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        busy,
    output logic        done,
    output logic        spi_cs_n,
    output logic        clr_n,
    output logic [1:0]  boper,
    output logic [1:0]  bmode,
    output logic [7:0]  tbyte,
    output logic [4:0]  dummy,
    input  logic [7:0]  rbyte,
    input  logic        bdone
);

    // The instruction, address and dummy steps are issued on the transition
    // that leaves the previous step, so their ISSUE substate takes no cycle
    // and only the WAIT substate is encoded. The data phase has a real ISSUE
    // substate (S_DATA_I) because it can stall on tx_valid or on rx_ready.
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_SETUP  = 4'd1;
    localparam logic [3:0] S_INS_W  = 4'd2;
    localparam logic [3:0] S_ADDR_W = 4'd3;
    localparam logic [3:0] S_DMY_W  = 4'd4;
    localparam logic [3:0] S_DATA_I = 4'd5;
    localparam logic [3:0] S_DATA_W = 4'd6;
    localparam logic [3:0] S_HOLD   = 4'd7;
    localparam logic [3:0] S_GAP    = 4'd8;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_DUMMY = 2'b11;

    localparam logic [3:0] GAP_LOAD = 4'(CSH_CYC - 1);

    // Lengths of 5..7 address bytes behave as 4.
    function automatic logic [2:0] addr_clamp(input logic [2:0] len);
        addr_clamp = (len > 3'd4) ? 3'd4 : len;
    endfunction

    // Left-align the used address bytes so the next byte is always [31:24].
    function automatic logic [31:0] addr_align(input logic [2:0] len, input logic [31:0] a);
        case (len)
            3'd1:    addr_align = {a[7:0], 24'h000000};
            3'd2:    addr_align = {a[15:0], 16'h0000};
            3'd3:    addr_align = {a[23:0], 8'h00};
            3'd4:    addr_align = a;
            default: addr_align = 32'h00000000;
        endcase
    endfunction

    logic [3:0]  state_r, nxt_state_s;
    logic        ins_pend_r, nxt_ins_pend_s;
    logic [7:0]  ins_r, nxt_ins_s;
    logic [1:0]  ins_mode_r, nxt_ins_mode_s;
    logic [31:0] addr_sh_r, nxt_addr_sh_s;
    logic [2:0]  addr_cnt_r, nxt_addr_cnt_s;
    logic [1:0]  addr_mode_r, nxt_addr_mode_s;
    logic        dmy_pend_r, nxt_dmy_pend_s;
    logic [4:0]  dmy_r, nxt_dmy_s;
    logic        rd_r, nxt_rd_s;
    logic [1:0]  data_mode_r, nxt_data_mode_s;
    logic [15:0] cnt_r, nxt_cnt_s;
    logic [3:0]  gap_r, nxt_gap_s;
    logic        tx_ready_r, nxt_tx_ready_s;
    logic [7:0]  rx_data_r, nxt_rx_data_s;
    logic        rx_valid_r, nxt_rx_valid_s;
    logic        busy_r, nxt_busy_s;
    logic        done_r, nxt_done_s;
    logic        cs_n_r, nxt_cs_n_s;
    logic        clr_n_r, nxt_clr_n_s;
    logic [1:0]  boper_r, nxt_boper_s;
    logic [1:0]  bmode_r, nxt_bmode_s;
    logic [7:0]  tbyte_r, nxt_tbyte_s;
    logic [4:0]  dummy_r, nxt_dummy_s;

    logic [3:0]  adv_state_s;
    logic        adv_ins_pend_s;
    logic [31:0] adv_addr_sh_s;
    logic [2:0]  adv_addr_cnt_s;
    logic        adv_dmy_pend_s;
    logic [1:0]  adv_boper_s;
    logic [1:0]  adv_bmode_s;
    logic [7:0]  adv_tbyte_s;
    logic [4:0]  adv_dummy_s;

    assign tx_ready = tx_ready_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign spi_cs_n = cs_n_r;
    assign clr_n    = clr_n_r;
    assign boper    = boper_r;
    assign bmode    = bmode_r;
    assign tbyte    = tbyte_r;
    assign dummy    = dummy_r;

    // Pick the next pending step in phase order INS -> ADDR -> DMY -> DATA.
    always_comb begin
        adv_state_s    = S_HOLD;
        adv_ins_pend_s = ins_pend_r;
        adv_addr_sh_s  = addr_sh_r;
        adv_addr_cnt_s = addr_cnt_r;
        adv_dmy_pend_s = dmy_pend_r;
        adv_boper_s    = OP_NONE;
        adv_bmode_s    = bmode_r;
        adv_tbyte_s    = tbyte_r;
        adv_dummy_s    = dummy_r;
        if (ins_pend_r) begin
            adv_state_s    = S_INS_W;
            adv_ins_pend_s = 1'b0;
            adv_boper_s    = OP_WRITE;
            adv_bmode_s    = ins_mode_r;
            adv_tbyte_s    = ins_r;
        end else if (addr_cnt_r != 3'd0) begin
            adv_state_s    = S_ADDR_W;
            adv_addr_cnt_s = addr_cnt_r - 3'd1;
            adv_addr_sh_s  = {addr_sh_r[23:0], 8'h00};
            adv_boper_s    = OP_WRITE;
            adv_bmode_s    = addr_mode_r;
            adv_tbyte_s    = addr_sh_r[31:24];
        end else if (dmy_pend_r) begin
            adv_state_s    = S_DMY_W;
            adv_dmy_pend_s = 1'b0;
            adv_boper_s    = OP_DUMMY;
            adv_bmode_s    = data_mode_r;
            adv_dummy_s    = dmy_r;
        end else if (cnt_r != 16'd0) begin
            if (rd_r) begin
                adv_state_s = S_DATA_W;
                adv_boper_s = OP_READ;
                adv_bmode_s = data_mode_r;
            end else begin
                adv_state_s = S_DATA_I;
            end
        end else begin
            adv_state_s = S_HOLD;
        end
    end

    // Frame sequencer: next value of every register.
    always_comb begin
        nxt_state_s     = state_r;
        nxt_ins_pend_s  = ins_pend_r;
        nxt_ins_s       = ins_r;
        nxt_ins_mode_s  = ins_mode_r;
        nxt_addr_sh_s   = addr_sh_r;
        nxt_addr_cnt_s  = addr_cnt_r;
        nxt_addr_mode_s = addr_mode_r;
        nxt_dmy_pend_s  = dmy_pend_r;
        nxt_dmy_s       = dmy_r;
        nxt_rd_s        = rd_r;
        nxt_data_mode_s = data_mode_r;
        nxt_cnt_s       = cnt_r;
        nxt_gap_s       = gap_r;
        nxt_rx_data_s   = rx_data_r;
        nxt_rx_valid_s  = rx_valid_r;
        nxt_done_s      = 1'b0;
        nxt_clr_n_s     = 1'b1;
        nxt_boper_s     = OP_NONE;
        nxt_bmode_s     = bmode_r;
        nxt_tbyte_s     = tbyte_r;
        nxt_dummy_s     = dummy_r;

        case (state_r)
            S_IDLE: begin
                if (start && !abort) begin
                    nxt_state_s     = S_SETUP;
                    nxt_ins_pend_s  = ins_en;
                    nxt_ins_s       = ins;
                    nxt_ins_mode_s  = ins_mode;
                    nxt_addr_sh_s   = addr_align(addr_clamp(addr_len), addr);
                    nxt_addr_cnt_s  = addr_clamp(addr_len);
                    nxt_addr_mode_s = addr_mode;
                    nxt_dmy_pend_s  = (dmy_cyc != 5'd0);
                    nxt_dmy_s       = dmy_cyc;
                    nxt_rd_s        = data_rd;
                    nxt_data_mode_s = data_mode;
                    nxt_cnt_s       = data_len;
                end else begin
                    nxt_state_s = S_IDLE;
                end
            end
            S_SETUP, S_INS_W, S_ADDR_W, S_DMY_W: begin
                // bdone only matters in a WAIT substate; SETUP always advances.
                if ((state_r == S_SETUP) || bdone) begin
                    nxt_state_s    = adv_state_s;
                    nxt_ins_pend_s = adv_ins_pend_s;
                    nxt_addr_sh_s  = adv_addr_sh_s;
                    nxt_addr_cnt_s = adv_addr_cnt_s;
                    nxt_dmy_pend_s = adv_dmy_pend_s;
                    nxt_boper_s    = adv_boper_s;
                    nxt_bmode_s    = adv_bmode_s;
                    nxt_tbyte_s    = adv_tbyte_s;
                    nxt_dummy_s    = adv_dummy_s;
                end else begin
                    nxt_state_s = state_r;
                end
            end
            S_DATA_I: begin
                if (rd_r) begin
                    // The previous byte must be accepted before the next read.
                    if (!rx_valid_r || rx_ready) begin
                        nxt_rx_valid_s = 1'b0;
                        if (cnt_r != 16'd0) begin
                            nxt_state_s = S_DATA_W;
                            nxt_boper_s = OP_READ;
                            nxt_bmode_s = data_mode_r;
                        end else begin
                            nxt_state_s = S_HOLD;
                        end
                    end else begin
                        nxt_state_s = S_DATA_I;
                    end
                end else begin
                    if (tx_valid && tx_ready_r) begin
                        nxt_state_s = S_DATA_W;
                        nxt_boper_s = OP_WRITE;
                        nxt_bmode_s = data_mode_r;
                        nxt_tbyte_s = tx_data;
                    end else begin
                        nxt_state_s = S_DATA_I;
                    end
                end
            end
            S_DATA_W: begin
                if (bdone) begin
                    nxt_cnt_s = cnt_r - 16'd1;
                    if (rd_r) begin
                        nxt_rx_data_s  = rbyte;
                        nxt_rx_valid_s = 1'b1;
                        nxt_state_s    = S_DATA_I;
                    end else if (cnt_r == 16'd1) begin
                        nxt_state_s = S_HOLD;
                    end else begin
                        nxt_state_s = S_DATA_I;
                    end
                end else begin
                    nxt_state_s = S_DATA_W;
                end
            end
            S_HOLD: begin
                nxt_state_s = S_GAP;
                nxt_done_s  = 1'b1;
                nxt_gap_s   = GAP_LOAD;
            end
            S_GAP: begin
                if (gap_r == 4'd0) begin
                    nxt_state_s = S_IDLE;
                end else begin
                    nxt_gap_s = gap_r - 4'd1;
                end
            end
            default: begin
                nxt_state_s = S_IDLE;
            end
        endcase

        // Abort drops the frame from any active state and clears the engine.
        if (abort && (state_r != S_IDLE)) begin
            nxt_state_s    = S_GAP;
            nxt_gap_s      = GAP_LOAD;
            nxt_boper_s    = OP_NONE;
            nxt_clr_n_s    = 1'b0;
            nxt_rx_valid_s = 1'b0;
            nxt_done_s     = 1'b0;
        end else begin
            nxt_clr_n_s = 1'b1;
        end

        nxt_busy_s     = (nxt_state_s != S_IDLE);
        nxt_cs_n_s     = (nxt_state_s == S_IDLE) || (nxt_state_s == S_GAP);
        nxt_tx_ready_s = (nxt_state_s == S_DATA_I) && !nxt_rd_s;
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            ins_pend_r  <= 1'b0;
            ins_r       <= 8'h00;
            ins_mode_r  <= 2'b00;
            addr_sh_r   <= 32'h00000000;
            addr_cnt_r  <= 3'd0;
            addr_mode_r <= 2'b00;
            dmy_pend_r  <= 1'b0;
            dmy_r       <= 5'd0;
            rd_r        <= 1'b0;
            data_mode_r <= 2'b00;
            cnt_r       <= 16'd0;
            gap_r       <= 4'd0;
            tx_ready_r  <= 1'b0;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cs_n_r      <= 1'b1;
            clr_n_r     <= 1'b1;
            boper_r     <= 2'b00;
            bmode_r     <= 2'b00;
            tbyte_r     <= 8'h00;
            dummy_r     <= 5'd0;
        end else begin
            state_r     <= nxt_state_s;
            ins_pend_r  <= nxt_ins_pend_s;
            ins_r       <= nxt_ins_s;
            ins_mode_r  <= nxt_ins_mode_s;
            addr_sh_r   <= nxt_addr_sh_s;
            addr_cnt_r  <= nxt_addr_cnt_s;
            addr_mode_r <= nxt_addr_mode_s;
            dmy_pend_r  <= nxt_dmy_pend_s;
            dmy_r       <= nxt_dmy_s;
            rd_r        <= nxt_rd_s;
            data_mode_r <= nxt_data_mode_s;
            cnt_r       <= nxt_cnt_s;
            gap_r       <= nxt_gap_s;
            tx_ready_r  <= nxt_tx_ready_s;
            rx_data_r   <= nxt_rx_data_s;
            rx_valid_r  <= nxt_rx_valid_s;
            busy_r      <= nxt_busy_s;
            done_r      <= nxt_done_s;
            cs_n_r      <= nxt_cs_n_s;
            clr_n_r     <= nxt_clr_n_s;
            boper_r     <= nxt_boper_s;
            bmode_r     <= nxt_bmode_s;
            tbyte_r     <= nxt_tbyte_s;
            dummy_r     <= nxt_dummy_s;
        end
    end

endmodule

// File: tb/tb_spim_xfer.sv
// tb_spim_xfer: scoreboard bench for spim_xfer with a reactive byte-engine model.
module tb_spim_xfer;

    localparam int CSH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic        ins_en;
    logic [1:0]  ins_mode;
    logic [7:0]  ins;
    logic [2:0]  addr_len;
    logic [1:0]  addr_mode;
    logic [31:0] addr;
    logic [4:0]  dmy_cyc;
    logic        data_rd;
    logic [1:0]  data_mode;
    logic [15:0] data_len;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready;
    logic        busy, done, spi_cs_n, clr_n;
    logic [1:0]  boper, bmode;
    logic [7:0]  tbyte, rbyte;
    logic [4:0]  dummy;
    logic        bdone;

    always #5 clk = ~clk;

    spim_xfer #(.CSH_CYC(CSH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .ins_en(ins_en), .ins_mode(ins_mode), .ins(ins),
        .addr_len(addr_len), .addr_mode(addr_mode), .addr(addr),
        .dmy_cyc(dmy_cyc), .data_rd(data_rd), .data_mode(data_mode), .data_len(data_len),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .done(done), .spi_cs_n(spi_cs_n), .clr_n(clr_n),
        .boper(boper), .bmode(bmode), .tbyte(tbyte), .dummy(dummy),
        .rbyte(rbyte), .bdone(bdone)
    );

    typedef struct packed {
        logic [1:0] op;
        logic [1:0] mode;
        logic [7:0] tb;
        logic [4:0] dm;
    } op_t;

    op_t        exp_ops[$];
    logic [7:0] exp_rx[$];
    logic [7:0] rd_bytes[$];
    logic [7:0] wb[3] = '{8'h11, 8'h22, 8'h33};

    int vec_cnt = 0;
    int err_cnt = 0;
    int done_cnt = 0;
    int op_cnt = 0;
    int csn_low_cnt = 0;
    bit in_frame = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic op_t mk(input logic [1:0] o, input logic [1:0] m, input logic [7:0] t, input logic [4:0] d);
        op_t r;
        r.op = o; r.mode = m; r.tb = t; r.dm = d;
        return r;
    endfunction

    // Byte-engine model and output monitor, sampled on the falling edge.
    initial begin : engine
        op_t e;
        bit  busy_e;
        bit  is_rd;
        int  tmr;
        busy_e = 1'b0; is_rd = 1'b0; tmr = 0;
        bdone = 1'b0; rbyte = 8'h00;
        forever begin
            @(negedge clk);
            bdone = 1'b0;
            if (!rst_n) begin
                busy_e = 1'b0;
            end else begin
                if (done) begin
                    done_cnt++;
                    in_frame = 1'b0;
                    check_val("cs_at_done", spi_cs_n, 1'b1);
                end
                if (in_frame) check_val("cs_in_frame", spi_cs_n, 1'b0);
                if (!spi_cs_n) csn_low_cnt++;
                if (!clr_n) busy_e = 1'b0;
                if (boper != 2'b00) begin
                    op_cnt++;
                    check_val("op_overlap", busy_e, 1'b0);
                    if (exp_ops.size() == 0) begin
                        check_val("op_unexpected", boper, 2'b00);
                    end else begin
                        e = exp_ops.pop_front();
                        check_val("op_code", boper, e.op);
                        if (e.op == 2'b01 || e.op == 2'b10) check_val("op_mode", bmode, e.mode);
                        if (e.op == 2'b01) check_val("op_tbyte", tbyte, e.tb);
                        if (e.op == 2'b11) check_val("op_dummy", dummy, e.dm);
                    end
                    busy_e = 1'b1; tmr = 3; is_rd = (boper == 2'b10);
                end else if (busy_e) begin
                    tmr--;
                    if (tmr == 0) begin
                        busy_e = 1'b0;
                        bdone = 1'b1;
                        if (is_rd) rbyte = (rd_bytes.size() > 0) ? rd_bytes.pop_front() : 8'h00;
                    end
                end
                if (rx_valid && rx_ready) begin
                    if (exp_rx.size() == 0) check_val("rx_unexpected", rx_data, 8'h00);
                    else check_val("rx_data", rx_data, exp_rx.pop_front());
                end
            end
        end
    end

    // Start a frame, then scramble the inputs to prove they were latched.
    task automatic launch(input logic i_en, input logic [7:0] i_op, input logic [1:0] i_md,
                          input logic [2:0] a_len, input logic [31:0] a_val, input logic [1:0] a_md,
                          input logic [4:0] d_cyc, input logic rd, input logic [1:0] d_md,
                          input logic [15:0] d_len);
        bit  has_op;
        op_t first;
        has_op = (exp_ops.size() > 0);
        first  = has_op ? exp_ops[0] : mk(2'b00, 2'b00, 8'h00, 5'd0);
        ins_en = i_en; ins = i_op; ins_mode = i_md;
        addr_len = a_len; addr = a_val; addr_mode = a_md;
        dmy_cyc = d_cyc; data_rd = rd; data_mode = d_md; data_len = d_len;
        csn_low_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("setup_cs", spi_cs_n, 1'b0);
        check_val("setup_busy", busy, 1'b1);
        check_val("setup_boper", boper, 2'b00);
        in_frame = 1'b1;
        ins = ~i_op; addr = ~a_val; addr_len = 3'd0; dmy_cyc = 5'd9;
        data_rd = ~rd; data_len = 16'd9; ins_en = ~i_en;
        tick();
        if (has_op) check_val("first_op_t2", boper, first.op);
    endtask

    task automatic wait_done(input int exp_done);
        int n = 0;
        while (done_cnt < exp_done && n < 400) begin tick(); n++; end
        check_val("done_seen", done_cnt, exp_done);
        n = 0;
        while (busy && n < 50) begin tick(); n++; end
        check_val("idle_after", busy, 1'b0);
        check_val("done_once", done_cnt, exp_done);
        check_val("ops_left", exp_ops.size(), 0);
        check_val("rx_left", exp_rx.size(), 0);
    endtask

    initial begin : main
        int n;
        int base;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        ins_en = 1'b0; ins_mode = 2'b00; ins = 8'h00;
        addr_len = 3'd0; addr_mode = 2'b00; addr = 32'h0;
        dmy_cyc = 5'd0; data_rd = 1'b0; data_mode = 2'b00; data_len = 16'd0;
        tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b1;
        tick(); tick();
        check_val("rst_cs_n", spi_cs_n, 1'b1);
        check_val("rst_clr_n", clr_n, 1'b1);
        check_val("rst_boper", boper, 2'b00);
        check_val("rst_bmode", bmode, 2'b00);
        check_val("rst_tbyte", tbyte, 8'h00);
        check_val("rst_dummy", dummy, 5'd0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_tx_ready", tx_ready, 1'b0);
        check_val("rst_rx", {rx_valid, rx_data}, 9'h000);
        rst_n = 1'b1;
        tick(); tick();

        // Single read 0x03, 3 address bytes, two data bytes.
        exp_ops.push_back(mk(2'b01, 2'b00, 8'h03, 5'd0));
        exp_ops.push_back(mk(2'b01, 2'b00, 8'h12, 5'd0));
        exp_ops.push_back(mk(2'b01, 2'b00, 8'h34, 5'd0));
        exp_ops.push_back(mk(2'b01, 2'b00, 8'h56, 5'd0));
        exp_ops.push_back(mk(2'b10, 2'b00, 8'h00, 5'd0));
        exp_ops.push_back(mk(2'b10, 2'b00, 8'h00, 5'd0));
        rd_bytes.push_back(8'hA5); rd_bytes.push_back(8'h5A);
        exp_rx.push_back(8'hA5);   exp_rx.push_back(8'h5A);
        launch(1'b1, 8'h03, 2'b00, 3'd3, 32'h00123456, 2'b00, 5'd0, 1'b1, 2'b00, 16'd2);
        wait_done(1);

        // Quad read 0xEB with 6 dummy clocks.
        exp_ops.push_back(mk(2'b01, 2'b00, 8'hEB, 5'd0));
        exp_ops.push_back(mk(2'b01, 2'b10, 8'hAB, 5'd0));
        exp_ops.push_back(mk(2'b01, 2'b10, 8'hCD, 5'd0));
        exp_ops.push_back(mk(2'b01, 2'b10, 8'hEF, 5'd0));
        exp_ops.push_back(mk(2'b11, 2'b10, 8'h00, 5'd6));
        exp_ops.push_back(mk(2'b10, 2'b10, 8'h00, 5'd0));
        rd_bytes.push_back(8'h3C); exp_rx.push_back(8'h3C);
        launch(1'b1, 8'hEB, 2'b00, 3'd3, 32'h00ABCDEF, 2'b10, 5'd6, 1'b1, 2'b10, 16'd2 - 16'd1);
        wait_done(2);

        // Write of 3 bytes, addr_len 7 behaves as 4, stall before byte 2.
        exp_ops.push_back(mk(2'b01, 2'b01, 8'hDE, 5'd0));
        exp_ops.push_back(mk(2'b01, 2'b01, 8'hAD, 5'd0));
        exp_ops.push_back(mk(2'b01, 2'b01, 8'hBE, 5'd0));
        exp_ops.push_back(mk(2'b01, 2'b01, 8'hEF, 5'd0));
        for (int i = 0; i < 3; i++) exp_ops.push_back(mk(2'b01, 2'b01, wb[i], 5'd0));
        launch(1'b0, 8'h00, 2'b00, 3'd7, 32'hDEADBEEF, 2'b01, 5'd0, 1'b0, 2'b01, 16'd3);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                for (int k = 0; k < 20; k++) begin
                    tick();
                    check_val("stall_no_op", boper, 2'b00);
                end
            end
            tx_data = wb[i]; tx_valid = 1'b1;
            n = 0;
            while (!tx_ready && n < 200) begin tick(); n++; end
            check_val("tx_ready_seen", tx_ready, 1'b1);
            tick();
            tx_valid = 1'b0;
            check_val("tx_ready_drop", tx_ready, 1'b0);
        end
        wait_done(3);

        // Read of 2 bytes with the consumer stalled for 10 cycles.
        exp_ops.push_back(mk(2'b01, 2'b00, 8'h0B, 5'd0));
        exp_ops.push_back(mk(2'b01, 2'b00, 8'h77, 5'd0));
        exp_ops.push_back(mk(2'b10, 2'b00, 8'h00, 5'd0));
        exp_ops.push_back(mk(2'b10, 2'b00, 8'h00, 5'd0));
        rd_bytes.push_back(8'h81); rd_bytes.push_back(8'h82);
        exp_rx.push_back(8'h81);   exp_rx.push_back(8'h82);
        rx_ready = 1'b0;
        launch(1'b1, 8'h0B, 2'b00, 3'd1, 32'h00000077, 2'b00, 5'd0, 1'b1, 2'b00, 16'd2);
        n = 0;
        while (!rx_valid && n < 200) begin tick(); n++; end
        base = op_cnt;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_val("rx_hold_valid", rx_valid, 1'b1);
            check_val("rx_hold_data", rx_data, 8'h81);
        end
        check_val("rx_no_early_read", op_cnt, base);
        rx_ready = 1'b1;
        wait_done(4);

        // Abort during an address byte, plus a start that arrives during GAP.
        exp_ops.push_back(mk(2'b01, 2'b00, 8'h02, 5'd0));
        exp_ops.push_back(mk(2'b01, 2'b00, 8'h01, 5'd0));
        base = op_cnt;
        launch(1'b1, 8'h02, 2'b00, 3'd3, 32'h00010203, 2'b00, 5'd0, 1'b0, 2'b00, 16'd1);
        n = 0;
        while (op_cnt < base + 2 && n < 50) begin tick(); n++; end
        check_val("abort_reach_addr", op_cnt, base + 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        in_frame = 1'b0;
        check_val("abort_cs_n", spi_cs_n, 1'b1);
        check_val("abort_clr_n", clr_n, 1'b0);
        check_val("abort_boper", boper, 2'b00);
        check_val("abort_tx_ready", tx_ready, 1'b0);
        check_val("abort_busy", busy, 1'b1);
        ins_en = 1'b0; addr_len = 3'd0; dmy_cyc = 5'd0; data_len = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("gap_clr_n", clr_n, 1'b1);
        check_val("gap_busy", busy, 1'b1);
        check_val("gap_cs_n", spi_cs_n, 1'b1);
        tick();
        check_val("gap_end_busy", busy, 1'b0);
        check_val("gap_start_ignored", spi_cs_n, 1'b1);
        check_val("abort_no_done", done_cnt, 4);
        check_val("abort_ops_left", exp_ops.size(), 0);

        // Empty frame straight after the gap.
        launch(1'b0, 8'h00, 2'b00, 3'd0, 32'h0, 2'b00, 5'd0, 1'b0, 2'b00, 16'd0);
        wait_done(5);
        check_val("empty_cs_low", csn_low_cnt, 2);

        // Abort and start in the same idle cycle.
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check_val("abort_start_busy", busy, 1'b0);
        check_val("abort_start_cs", spi_cs_n, 1'b1);

        // Asynchronous reset in the middle of a frame.
        exp_ops.push_back(mk(2'b01, 2'b00, 8'h9F, 5'd0));
        exp_ops.push_back(mk(2'b10, 2'b00, 8'h00, 5'd0));
        rd_bytes.push_back(8'h44); exp_rx.push_back(8'h44);
        launch(1'b1, 8'h9F, 2'b00, 3'd0, 32'h0, 2'b00, 5'd0, 1'b1, 2'b00, 16'd1);
        #2;
        rst_n = 1'b0;
        in_frame = 1'b0;
        #1;
        check_val("arst_cs_n", spi_cs_n, 1'b1);
        check_val("arst_busy", busy, 1'b0);
        check_val("arst_boper", boper, 2'b00);
        exp_ops.delete(); exp_rx.delete(); rd_bytes.delete();
        base = op_cnt;
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check_val("arst_no_op", op_cnt, base);
        check_val("arst_no_done", done_cnt, 5);
        check_val("arst_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
